// File: rtl/median_window_ctrl.sv
// Purpose : streams a raster image through two line buffers and a 3x3 window, emitting interior-pixel medians.
// Latency : 1 cycle from the accepting clock edge of a window-completing pixel to out_valid.
// Backpr. : in_ready drops while a held median is not taken (out_valid && !out_ready) or while waiting out the frame tail.
//
// Ports:
//   clk, rst            - rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   - pixel input handshake, in_data carries the raster-order pixel
//   out_valid/out_ready - median output handshake, out_data carries the registered result
//   frame_done          - one-cycle pulse on the transfer of the final median of a frame
//   busy                - high from the first accepted pixel of a frame until frame_done
// Optional build macro MEDIAN_BYPASS_EN adds input 'bypass': when set while a result is
// produced, out_data carries the window centre tap instead of the median.
// Pixel vectors are declared [0:DATA_W-1] so bit 0 is the MSB.

module medianFilter (
    input  logic [0:7] t1,
    input  logic [0:7] t2,
    input  logic [0:7] t3,
    input  logic [0:7] t4,
    input  logic [0:7] t5,
    input  logic [0:7] t6,
    input  logic [0:7] t7,
    input  logic [0:7] t8,
    input  logic [0:7] t9,
    output logic [0:7] median
);
    logic [0:7] srt [0:8];
    logic [0:7] tmp;

    // Full compare-exchange sort of the nine taps; the middle element is the median.
    always_comb begin
        tmp    = '0;
        srt[0] = t1;
        srt[1] = t2;
        srt[2] = t3;
        srt[3] = t4;
        srt[4] = t5;
        srt[5] = t6;
        srt[6] = t7;
        srt[7] = t8;
        srt[8] = t9;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8 - i; j++) begin
                if (srt[j] > srt[j+1]) begin
                    tmp      = srt[j];
                    srt[j]   = srt[j+1];
                    srt[j+1] = tmp;
                end
            end
        end
        median = srt[4];
    end
endmodule

module median_window_ctrl #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [0:DATA_W-1] in_data,
`ifdef MEDIAN_BYPASS_EN
    input  logic              bypass,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [0:DATA_W-1] out_data,
    output logic              frame_done,
    output logic              busy
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [0:DATA_W-1] linebuf0 [0:IMG_W-1];
    logic [0:DATA_W-1] linebuf1 [0:IMG_W-1];
    logic [0:DATA_W-1] win      [0:8];
    logic [0:DATA_W-1] taps     [0:8];
    logic [0:7]        med;
    logic [0:DATA_W-1] result;

    logic accept;
    logic produce;
    logic col_wrap;
    logic last_px;
    logic out_xfer;

    assign out_xfer   = out_valid && out_ready;
    assign in_ready   = (state != DONE) && (!out_valid || out_ready);
    assign accept     = in_valid && in_ready;
    assign col_wrap   = (col == CW'(IMG_W - 1));
    assign last_px    = col_wrap && (row == RW'(IMG_H - 1));
    // The window holds a full interior neighbourhood once the accepted pixel is at row>=2, col>=2.
    assign produce    = accept && (row >= RW'(2)) && (col >= CW'(2));
    assign frame_done = (state == DONE) && out_xfer;
    assign busy       = (state != IDLE);

    // Taps describe the window as it will look after this cycle's shift, so the
    // median can be registered on the same edge that accepts the pixel.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            taps[3*r]   = win[3*r+1];
            taps[3*r+1] = win[3*r+2];
        end
        taps[2] = linebuf1[col];
        taps[5] = linebuf0[col];
        taps[8] = in_data;
    end

    medianFilter u_median (
        .t1     (taps[0]),
        .t2     (taps[1]),
        .t3     (taps[2]),
        .t4     (taps[3]),
        .t5     (taps[4]),
        .t6     (taps[5]),
        .t7     (taps[6]),
        .t8     (taps[7]),
        .t9     (taps[8]),
        .median (med)
    );

`ifdef MEDIAN_BYPASS_EN
    assign result = bypass ? taps[4] : med;
`else
    assign result = med;
`endif

    // Storage only; contents are refilled before any of them reach the output.
    always_ff @(posedge clk) begin
        if (accept) begin
            linebuf1[col] <= linebuf0[col];
            linebuf0[col] <= in_data;
            for (int i = 0; i < 9; i++) begin
                win[i] <= taps[i];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = PRIME;
                end
            end
            PRIME: begin
                if (accept && last_px) begin
                    state_nxt = DONE;
                end else if (produce) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (accept && last_px) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_xfer) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                if (col_wrap) begin
                    col <= '0;
                    // The final pixel wraps the row counter too, leaving both at 0 for the next frame.
                    row <= last_px ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    // A new result overrides the hold/clear decision, which keeps 1/cycle throughput
    // when a transfer and an acceptance coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (produce) begin
            out_valid <= 1'b1;
            out_data  <= result;
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_median_window_ctrl.sv
module tb_median_window_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [0:7] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [0:7] out_data;
    logic       frame_done;
    logic       busy;
    logic       bypass;

    logic       b_in_valid;
    logic       b_in_ready;
    logic [0:7] b_in_data;
    logic       b_out_valid;
    logic       b_out_ready;
    logic [0:7] b_out_data;
    logic       b_frame_done;
    logic       b_busy;
    logic       b_bypass;

    int n_chk  = 0;
    int n_pass = 0;

    logic [0:7] pix [0:15];
    int         exp_med [0:3];
    int         outq [$];
    int         fd_cnt = 0;

    always #5 clk = ~clk;

    median_window_ctrl #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
`ifdef MEDIAN_BYPASS_EN
        .bypass     (bypass),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .frame_done (frame_done),
        .busy       (busy)
    );

    median_window_ctrl #(.DATA_W(8), .IMG_W(3), .IMG_H(3)) dut_small (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .in_data    (b_in_data),
`ifdef MEDIAN_BYPASS_EN
        .bypass     (b_bypass),
`endif
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .out_data   (b_out_data),
        .frame_done (b_frame_done),
        .busy       (b_busy)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Watches the 4x4 instance: counts pixels, expects each result one edge after
    // its completing pixel, and logs every output transfer.
    int pix_idx = 0;
    int pend_k  = 0;
    bit pend    = 1'b0;
    always @(negedge clk) begin
        int r;
        int c;
        if (rst) begin
            pix_idx = 0;
            pend    = 1'b0;
        end else begin
            if (pend) begin
                chk($sformatf("lat_vld_k%0d", pend_k), out_valid, 1);
                chk($sformatf("lat_dat_k%0d", pend_k), out_data, exp_med[pend_k]);
                pend = 1'b0;
            end
            if (out_valid && out_ready) outq.push_back(int'(out_data));
            if (frame_done) begin
                fd_cnt++;
                chk("fd_with_xfer", {30'd0, out_valid, out_ready}, 3);
            end
            if (in_valid && in_ready) begin
                r = pix_idx / 4;
                c = pix_idx % 4;
                if (r >= 2 && c >= 2) begin
                    pend   = 1'b1;
                    pend_k = (r - 2) * 2 + (c - 2);
                end
                pix_idx = (pix_idx == 15) ? 0 : pix_idx + 1;
            end
        end
    end

    // Entered and left at 1 time unit after a rising edge.
    task automatic send(input int a, input int b, input bit gap);
        for (int k = a; k <= b; k++) begin
            int n;
            in_valid = 1'b1;
            in_data  = pix[k];
            n = 0;
            @(negedge clk);
            while (!in_ready && n < 50) begin
                n++;
                @(negedge clk);
            end
            if (!in_ready) chk($sformatf("send_timeout_px%0d", k), 0, 1);
            @(posedge clk); #1;
            if (gap) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_vld_end"}, out_valid, 0);
        @(posedge clk); #1;
    endtask

    task automatic check_frame(input string tag, input int fd_exp);
        chk({tag, "_count"}, outq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_m%0d", tag, i), (i < outq.size()) ? outq[i] : -1, exp_med[i]);
        end
        chk({tag, "_frame_done"}, fd_cnt, fd_exp);
    endtask

    task automatic set_ramp(input bit rev);
        for (int k = 0; k < 16; k++) pix[k] = rev ? 8'(15 - k) : 8'(k);
    endtask

    task automatic set_exp(input int e0, input int e1, input int e2, input int e3);
        exp_med[0] = e0;
        exp_med[1] = e1;
        exp_med[2] = e2;
        exp_med[3] = e3;
        outq.delete();
        fd_cnt = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b1;
        bypass      = 1'b0;
        b_in_valid  = 1'b0;
        b_in_data   = '0;
        b_out_ready = 1'b1;
        b_bypass    = 1'b0;
        set_ramp(1'b0);
        set_exp(5, 6, 9, 10);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Continuous ramp.
        set_ramp(1'b0);
        set_exp(5, 6, 9, 10);
        send(0, 15, 1'b0);
        @(negedge clk);
        chk("ramp_done_in_ready", in_ready, 0);
        chk("ramp_done_fd", frame_done, 1);
        chk("ramp_done_busy", busy, 1);
        wait_idle("ramp");
        check_frame("ramp", 1);

        // Backpressure right after the first median.
        set_exp(5, 6, 9, 10);
        send(0, 10, 1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = pix[11];
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk($sformatf("stall_vld_%0d", s), out_valid, 1);
            chk($sformatf("stall_dat_%0d", s), out_data, 5);
            chk($sformatf("stall_in_ready_%0d", s), in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(11, 15, 1'b0);
        wait_idle("stall");
        check_frame("stall", 1);

        // Input gaps on every other cycle.
        set_exp(5, 6, 9, 10);
        send(0, 0, 1'b1);
        @(negedge clk);
        chk("gap_busy_after_first", busy, 1);
        @(posedge clk); #1;
        send(1, 15, 1'b1);
        wait_idle("gap");
        check_frame("gap", 1);

        // Reset part way through a frame, then a full frame.
        set_exp(5, 6, 9, 10);
        send(0, 7, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        send(0, 15, 1'b0);
        wait_idle("mid_rst");
        check_frame("mid_rst", 1);

        // Descending ramp.
        set_ramp(1'b1);
        set_exp(10, 9, 6, 5);
        send(0, 15, 1'b0);
        wait_idle("rev");
        check_frame("rev", 1);

        // Lone bright pixel: medians reject it although it is a window centre.
        for (int k = 0; k < 16; k++) pix[k] = 8'd0;
        pix[5] = 8'd200;
        set_exp(0, 0, 0, 0);
        send(0, 15, 1'b0);
        wait_idle("spike");
        check_frame("spike", 1);

`ifdef MEDIAN_BYPASS_EN
        bypass = 1'b1;
        set_exp(200, 0, 0, 0);
        send(0, 15, 1'b0);
        wait_idle("byp_spike");
        check_frame("byp_spike", 1);
        set_ramp(1'b0);
        set_exp(5, 6, 9, 10);
        send(0, 15, 1'b0);
        wait_idle("byp_ramp");
        check_frame("byp_ramp", 1);
        set_ramp(1'b1);
        set_exp(10, 9, 6, 5);
        send(0, 15, 1'b0);
        wait_idle("byp_rev");
        check_frame("byp_rev", 1);
        bypass = 1'b0;
`endif

        // 3x3 impulse on the minimum-size instance.
        for (int k = 0; k < 9; k++) begin
            b_in_valid = 1'b1;
            b_in_data  = (k == 4) ? 8'hFF : 8'h40;
            @(negedge clk);
            chk($sformatf("imp_in_ready_%0d", k), b_in_ready, 1);
            chk($sformatf("imp_no_out_%0d", k), b_out_valid, 0);
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0;
        @(negedge clk);
        chk("imp_out_valid", b_out_valid, 1);
        chk("imp_out_data", b_out_data, 8'h40);
        chk("imp_frame_done", b_frame_done, 1);
        chk("imp_in_ready_done", b_in_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("imp_busy_end", b_busy, 0);
        chk("imp_out_valid_end", b_out_valid, 0);
        chk("imp_fd_end", b_frame_done, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
